mul_div_unit: RTL and testbench

Multi-cycle integer multiply/divide unit that owns the HI/LO register pair. It sits in the execute stage beside the ALU, taking the two register-file read operands. It produces the HI/LO values that the mfhi/mflo write-back mux selects. It replaces the single-cycle combinational multiplier and adds signed/unsigned divide, using a radix-2 iterative datapath with a start/busy/done handshake.

---
 rtl/mul_div_unit.sv | 185 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 iterative multiply/divide unit owning the HI/LO pair.
// MULTU/MULT use shift-add (LSB first); DIVU/DIV use restoring division
// (MSB first). Every op takes WIDTH CALC cycles plus one FIX cycle.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; mthi/mtlo write HI/LO directly
// CALC   | one multiplier/quotient bit per cycle, WIDTH cycles
// FIX    | apply result signs (or divide-by-zero result), write HI/LO
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   a_q, a_d;           // raw dividend, for the b==0 result
   logic               neg_q, neg_d;       // negate product / quotient
   logic               neg_rem_q, neg_rem_d;
   logic               bzero_q, bzero_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quot, rem;

   // Datapath helpers: operand magnitudes, one iteration step, sign fix-up.
   // The magnitude of the most negative value wraps to itself, which is the
   // correct unsigned magnitude.
   always_comb begin
      a_mag    = (op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
      b_mag    = (op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = rem_sh - {1'b0, opnd_q};
      product  = neg_q ? (~acc_q + 1'b1) : acc_q;
      quot     = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      rem      = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                           : acc_q[2*WIDTH-1:WIDTH];
   end

   // Next-state and register update logic.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      a_d       = a_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      bzero_d   = bzero_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dz_d      = dz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d      = op;
               a_d       = a;
               neg_d     = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_rem_d = op[0] & a[WIDTH-1];
               bzero_d   = (b == '0);
               acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
               opnd_d    = op[1] ? b_mag : a_mag;
               cnt_d     = '0;
               busy_d    = 1'b1;
               dz_d      = 1'b0;
               state_d   = S_CALC;
            end else begin
               if (mthi) hi_d = wd;
               if (mtlo) lo_d = wd;
            end
         end
         S_CALC: begin
            if (!op_q[1]) begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
               acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_FIX;
         end
         S_FIX: begin
            if (!op_q[1]) begin
               hi_d = product[2*WIDTH-1:WIDTH];
               lo_d = product[WIDTH-1:0];
            end else if (bzero_q) begin
               hi_d = a_q;
               lo_d = '1;
               dz_d = 1'b1;
            end else begin
               hi_d = rem;
               lo_d = quot;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         a_q       <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         a_q       <= a_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         bzero_q   <= bzero_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed vector table plus hand-written
// sequences for busy-time interference, mthi/mtlo and mid-operation reset.
module tb_mul_div_unit;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0, wd = '0;
   logic        mthi = 1'b0, mtlo = 1'b0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wd(wd), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one operation and check latency, result, flags and done width.
   // dis >= 0: in that CALC cycle drive start/mthi/mtlo (must be ignored).
   // mt_start: assert mtlo with start (start must win).
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int dis, input logic mt_start);
      int lat;
      logic [31:0] hi_before, lo_before;
      @(negedge clk);
      hi_before = hi;
      lo_before = lo;
      start = 1'b1; op = o; a = va; b = vb;
      if (mt_start) begin mtlo = 1'b1; wd = 32'hDEAD; end
      @(posedge clk); #1;
      start = 1'b0; mtlo = 1'b0;
      a = $urandom; b = $urandom;
      check({tag, " busy_after_start"}, {63'd0, busy}, 64'd1);
      check({tag, " dz_cleared"}, {63'd0, div_zero}, 64'd0);
      if (mt_start) check({tag, " lo_not_written"}, {32'd0, lo}, {32'd0, lo_before});
      lat = 0;
      while (!done && lat < 40) begin
         if (lat == dis) begin
            start = 1'b1; op = OP_DIV; a = 32'h11; b = 32'h3;
            mthi = 1'b1; mtlo = 1'b1; wd = 32'hAAAA;
         end
         @(posedge clk); #1;
         start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
         lat++;
         if (lat == 16) check({tag, " hi_hold"}, {32'd0, hi}, {32'd0, hi_before});
      end
      check({tag, " latency"}, lat, 64'd33);
      check({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
      check({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
      check({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, edz});
      check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      check({tag, " done_width"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[6]  = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
      vecs[7]  = '{OP_MULTU, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0};
      vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
      vecs[9]  = '{OP_DIV,   32'hFFFFFB2E, 32'd0,        32'hFFFFFB2E, 32'hFFFFFFFF, 1'b1};
      vecs[10] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
      vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};

      // Reset state
      #12;
      check("rst hi", {32'd0, hi}, 64'd0);
      check("rst lo", {32'd0, lo}, 64'd0);
      check("rst busy", {63'd0, busy}, 64'd0);
      check("rst done", {63'd0, done}, 64'd0);
      check("rst div_zero", {63'd0, div_zero}, 64'd0);
      @(negedge clk); reset = 1'b1;

      for (int i = 0; i < 12; i++)
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].hi, vecs[i].lo, vecs[i].dz, -1, 1'b0);

      // mthi + mtlo together in IDLE
      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; wd = 32'h55;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      check("mt hi", {32'd0, hi}, 64'h55);
      check("mt lo", {32'd0, lo}, 64'h55);

      // start/mthi/mtlo while busy are ignored; hi holds old value in CALC
      do_op("busy_ign", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 5, 1'b0);
      repeat (3) @(posedge clk);
      #1 check("no_queue busy", {63'd0, busy}, 64'd0);

      // start + mtlo together: start wins, lo untouched at accept
      do_op("start_mtlo", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, -1, 1'b1);

      // Reset at iteration 10 of a MULT
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'hFFFFFFFB; b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort hi", {32'd0, hi}, 64'd0);
      check("abort lo", {32'd0, lo}, 64'd0);
      check("abort busy", {63'd0, busy}, 64'd0);
      check("abort done", {63'd0, done}, 64'd0);
      @(negedge clk); reset = 1'b1;
      do_op("post_rst", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
